// File: rtl/i2c_target.sv
// I2C target (7-bit address) bridging bus writes to an AXI-Stream master port
// and bus reads from an AXI-Stream slave port; all logic runs on clk_i.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic       busy_o,
  output logic       err_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  // [0] metastable, [1] synchronized, [2] history
  logic [2:0] scl_ff, sda_ff;
  logic       scl_s, scl_p, sda_s, sda_p;
  logic       scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] m_tdata_q, m_tdata_d;
  logic       m_tvalid_q, m_tvalid_d;
  logic       s_tready_q, s_tready_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       load_rd;
  logic [7:0] rx_byte, rd_byte;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      scl_ff <= '1;
      sda_ff <= '1;
    end else begin
      scl_ff <= {scl_ff[1:0], scl_i};
      sda_ff <= {sda_ff[1:0], sda_i};
    end
  end

  assign scl_s     = scl_ff[1];
  assign scl_p     = scl_ff[2];
  assign sda_s     = sda_ff[1];
  assign sda_p     = sda_ff[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & sda_p & ~sda_s;
  assign stop_det  = scl_s & ~sda_p & sda_s;
  assign rx_byte   = {shreg_q[6:0], sda_s};
  assign rd_byte   = s_axis_tvalid ? s_axis_tdata : 8'hFF;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      phase_q    <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      s_tready_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      phase_q    <= phase_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      s_tready_q <= s_tready_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    phase_d    = phase_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    s_tready_d = 1'b0;
    busy_d     = busy_q;
    err_d      = 1'b0;
    load_rd    = 1'b0;

    if (m_tvalid_q && m_axis_tready) m_tvalid_d = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == TARGET_ADDR) begin
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
              phase_d = 1'b0;
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // phase_q: 0 = ACK not yet driven, 1 = ACK bit on the bus
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else if (rw_q) begin
            load_rd = 1'b1;
            state_d = RD_DATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WR_DATA;
          end
        end
        WR_DATA: if (scl_rise) begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            phase_d = 1'b0;
            state_d = WR_ACK;
            if (!m_tvalid_q) begin
              m_tdata_d  = rx_byte;
              m_tvalid_d = 1'b1;
              ack_d      = 1'b1;
            end else begin
              err_d = 1'b1;
              ack_d = 1'b0;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ack_q;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = ack_q ? WR_DATA : WAIT_STOP;
          end
        end
        // bit 7 is already on the bus when RD_DATA is entered
        RD_DATA: if (scl_fall) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = RD_ACK;
          end else begin
            shreg_d  = {shreg_q[6:0], 1'b0};
            sda_oe_d = ~shreg_q[6];
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = WAIT_STOP;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            load_rd = 1'b1;
            state_d = RD_DATA;
          end
        end
        default: ;
      endcase
    end

    if (load_rd) begin
      shreg_d    = rd_byte;
      sda_oe_d   = ~rd_byte[7];
      s_tready_d = s_axis_tvalid;
      err_d      = ~s_axis_tvalid;
    end
  end

  assign sda_oe_o      = sda_oe_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign s_axis_tready = s_tready_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, AXI-Stream source/sink models,
// expected bytes queued when stimulus is driven and compared as the DUT emits them.
module tb_i2c_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       arst;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       busy_o;
  logic       err_o;

  assign sda_bus = sda_m & ~sda_oe_o;

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .clk_i         (clk),
    .arst_i        (arst),
    .scl_i         (scl_m),
    .sda_i         (sda_bus),
    .sda_oe_o      (sda_oe_o),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // expected m_axis bytes: written by stimulus, consumed by the sink monitor
  logic [7:0] exp_m_mem [0:63];
  int         exp_m_wr = 0;
  int         exp_m_rd = 0;
  // s_axis source contents: written by stimulus, consumed on s_axis_tready
  logic [7:0] src_mem [0:15];
  int         src_wr = 0;
  int         src_rd = 0;
  logic [7:0] exp_rd [$];

  int   m_beats = 0, err_cnt = 0, rdy_cnt = 0, oe_rise = 0, busy_rise = 0;
  logic oe_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      m_beats++;
      if (exp_m_rd < exp_m_wr) begin
        check("m_axis_tdata", 32'(m_axis_tdata), 32'(exp_m_mem[exp_m_rd]));
        exp_m_rd++;
      end
    end
    if (err_o) err_cnt++;
    if (s_axis_tready) rdy_cnt++;
    if (sda_oe_o && !oe_prev) oe_rise++;
    if (busy_o && !busy_prev) busy_rise++;
    oe_prev   = sda_oe_o;
    busy_prev = busy_o;
    if (s_axis_tready && src_rd < src_wr) src_rd++;
    s_axis_tvalid = (src_rd < src_wr);
    s_axis_tdata  = (src_rd < src_wr) ? src_mem[src_rd] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus;  tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic push_m(input logic [7:0] d);
    exp_m_mem[exp_m_wr] = d;
    exp_m_wr++;
  endtask

  task automatic push_src(input logic [7:0] d);
    src_mem[src_wr] = d;
    src_wr++;
    exp_rd.push_back(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int b0, e0, r0, o0, u0;
    arst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; m_axis_tready = 1'b0;
    tick(5);
    check("rst_sda_oe", 32'(sda_oe_o), 0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
    check("rst_m_tdata", 32'(m_axis_tdata), 0);
    check("rst_s_tready", 32'(s_axis_tready), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_err", 32'(err_o), 0);
    arst = 1'b0;
    tick(10);

    // write 0x3C to matching address
    m_axis_tready = 1'b1;
    b0 = m_beats; e0 = err_cnt; o0 = oe_rise;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t1_addr_ack", 32'(ack), 1);
    check("t1_busy", 32'(busy_o), 1);
    push_m(8'h3C);
    write_byte(8'h3C, ack);
    check("t1_data_ack", 32'(ack), 1);
    i2c_stop();
    tick(4);
    check("t1_busy_after_stop", 32'(busy_o), 0);
    check("t1_beats", 32'(m_beats - b0), 1);
    check("t1_oe_pulses", 32'(oe_rise - o0), 2);
    check("t1_err", 32'(err_cnt - e0), 0);

    // read 0x5A (ACK) then 0xC3 (NACK)
    e0 = err_cnt; r0 = rdy_cnt;
    push_src(8'h5A);
    push_src(8'hC3);
    tick(4);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t2_addr_ack", 32'(ack), 1);
    read_byte(d, 1'b0);
    check("t2_byte0", 32'(d), 32'(exp_rd.pop_front()));
    read_byte(d, 1'b1);
    check("t2_byte1", 32'(d), 32'(exp_rd.pop_front()));
    i2c_stop();
    tick(4);
    check("t2_tready_pulses", 32'(rdy_cnt - r0), 2);
    check("t2_err", 32'(err_cnt - e0), 0);
    check("t2_busy", 32'(busy_o), 0);

    // address mismatch
    b0 = m_beats; o0 = oe_rise; u0 = busy_rise;
    i2c_start();
    write_byte(8'h42, ack);
    check("t3_addr_nack", 32'(ack), 0);
    write_byte(8'h11, ack);
    check("t3_data_nack", 32'(ack), 0);
    i2c_stop();
    tick(4);
    check("t3_oe_pulses", 32'(oe_rise - o0), 0);
    check("t3_busy_rises", 32'(busy_rise - u0), 0);
    check("t3_beats", 32'(m_beats - b0), 0);

    // overrun: sink stalled
    m_axis_tready = 1'b0;
    b0 = m_beats; e0 = err_cnt;
    push_m(8'h01);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t4_addr_ack", 32'(ack), 1);
    write_byte(8'h01, ack);
    check("t4_byte1_ack", 32'(ack), 1);
    write_byte(8'h02, ack);
    check("t4_byte2_nack", 32'(ack), 0);
    i2c_stop();
    tick(4);
    check("t4_err", 32'(err_cnt - e0), 1);
    check("t4_held_tvalid", 32'(m_axis_tvalid), 1);
    check("t4_held_tdata", 32'(m_axis_tdata), 32'h01);
    check("t4_beats_stalled", 32'(m_beats - b0), 0);
    m_axis_tready = 1'b1;
    tick(4);
    check("t4_beats", 32'(m_beats - b0), 1);
    check("t4_tvalid_clear", 32'(m_axis_tvalid), 0);

    // write then repeated START into an underrunning read
    b0 = m_beats; e0 = err_cnt; r0 = rdy_cnt;
    push_m(8'h07);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t5_addr_ack", 32'(ack), 1);
    write_byte(8'h07, ack);
    check("t5_data_ack", 32'(ack), 1);
    i2c_start();
    write_byte(8'hA1, ack);
    check("t5_raddr_ack", 32'(ack), 1);
    read_byte(d, 1'b1);
    check("t5_underrun_byte", 32'(d), 32'hFF);
    i2c_stop();
    tick(4);
    check("t5_err", 32'(err_cnt - e0), 1);
    check("t5_beats", 32'(m_beats - b0), 1);
    check("t5_tready_pulses", 32'(rdy_cnt - r0), 0);

    // reset during data bit 4, then a clean transfer
    b0 = m_beats;
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_addr_ack", 32'(ack), 1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b1);
    arst = 1'b1;
    #1;
    check("t6_rst_sda_oe", 32'(sda_oe_o), 0);
    check("t6_rst_busy", 32'(busy_o), 0);
    check("t6_rst_m_tdata", 32'(m_axis_tdata), 0);
    tick(3);
    arst = 1'b0;
    tick(2);
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    read_bit(ack);
    check("t6_aborted_nack", 32'(ack), 1);
    i2c_stop();
    tick(4);
    check("t6_no_beat", 32'(m_beats - b0), 0);
    push_m(8'h96);
    i2c_start();
    write_byte(8'hA0, ack);
    check("t6_addr2_ack", 32'(ack), 1);
    write_byte(8'h96, ack);
    check("t6_data2_ack", 32'(ack), 1);
    i2c_stop();
    tick(4);
    check("t6_beats", 32'(m_beats - b0), 1);
    check("t6_sink_drained", 32'(exp_m_rd), 32'(exp_m_wr));
    check("t6_src_drained", 32'(src_rd), 32'(src_wr));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
